// File: rtl/rtmc_pkg.sv
// Shared frame layout, timeout fill value and bus FSM state type for the
// motor-controller SPI bridge.
package rtmc_pkg;

  localparam int FRAME_BITS  = 32;
  localparam int HALF_BITS   = FRAME_BITS / 2;
  localparam int RW_BIT      = 31;
  localparam int CLR_ERR_BIT = 30;
  localparam int ADDR_MSB    = 23;
  localparam int ADDR_LSB    = 16;

  localparam logic [15:0] TIMEOUT_FILL = 16'hFFFF;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_REQ  = 2'd1,
    BUS_WAIT = 2'd2
  } bus_state_t;

endpackage

// File: rtl/rtmc_sync.sv
// Two-flop synchronizer with a selectable reset value per bit.
module rtmc_sync #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rtmc_spi_bridge.sv
// SPI mode-0 target that turns 32-bit host frames into single register-bus
// accesses; read data returns in the second half of the same frame.
module rtmc_spi_bridge
  import rtmc_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdat,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdat,
  input  logic              reg_ack,
  output logic              err,
  output logic              busy
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic sclk_s, cs_n_s, mosi_s, sclk_q;
  logic sclk_rise, sclk_fall, cs_act;

  rtmc_sync #(.W(1), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi_sclk), .q(sclk_s)
  );
  rtmc_sync #(.W(1), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_n_s)
  );
  rtmc_sync #(.W(1), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sclk_q <= 1'b0;
    else        sclk_q <= sclk_s;
  end

  assign sclk_rise   = sclk_s & ~sclk_q;
  assign sclk_fall   = ~sclk_s & sclk_q;
  assign cs_act      = ~cs_n_s;
  assign spi_miso_oe = cs_act;

  // ---------------- frame shifter ----------------
  logic [FRAME_BITS-1:0] shift, shift_nxt;
  logic [5:0]            bit_cnt;
  logic [DATA_W-1:0]     tx, rd_buf;
  logic                  rd_frame;
  logic                  take, hit16, hit32, launch_rd, launch_wr;

  assign shift_nxt = {shift[FRAME_BITS-2:0], mosi_s};
  assign take      = cs_act & sclk_rise & (bit_cnt < 6'(FRAME_BITS));
  assign hit16     = take & (bit_cnt == 6'(HALF_BITS - 1));
  assign hit32     = take & (bit_cnt == 6'(FRAME_BITS - 1));
  // at bit 16 the frame's upper half sits in shift_nxt[15:0]
  assign launch_rd = hit16 & shift_nxt[RW_BIT-HALF_BITS];
  assign launch_wr = hit32 & ~shift_nxt[RW_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift    <= '0;
      bit_cnt  <= '0;
      rd_frame <= 1'b0;
      tx       <= '0;
      spi_miso <= 1'b0;
    end else if (!cs_act) begin
      shift    <= '0;
      bit_cnt  <= '0;
      rd_frame <= 1'b0;
      tx       <= '0;
      spi_miso <= 1'b0;
    end else begin
      if (take) begin
        shift   <= shift_nxt;
        bit_cnt <= bit_cnt + 6'd1;
        if (hit16) rd_frame <= shift_nxt[RW_BIT-HALF_BITS];
      end
      if (sclk_fall) begin
        if (rd_frame && bit_cnt == 6'(HALF_BITS)) begin
          spi_miso <= rd_buf[DATA_W-1];
          tx       <= {rd_buf[DATA_W-2:0], 1'b0};
        end else begin
          spi_miso <= tx[DATA_W-1];
          tx       <= {tx[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  // ---------------- bus initiator ----------------
  bus_state_t    state;
  logic [TW-1:0] timer;
  logic          pend, pend_rd, cur_rd;

  assign busy = (state != BUS_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BUS_IDLE;
      timer    <= '0;
      pend     <= 1'b0;
      pend_rd  <= 1'b0;
      cur_rd   <= 1'b0;
      reg_addr <= '0;
      reg_wdat <= '0;
      reg_wr   <= 1'b0;
      reg_rd   <= 1'b0;
      rd_buf   <= '0;
      err      <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      if (hit16) begin
        reg_addr <= ADDR_W'(shift_nxt[ADDR_MSB-HALF_BITS:ADDR_LSB-HALF_BITS]);
        if (shift_nxt[CLR_ERR_BIT-HALF_BITS]) err <= 1'b0;
      end
      if (launch_wr) reg_wdat <= DATA_W'(shift_nxt[15:0]);

      // single pending slot; a fresh launch wins over the slot being consumed
      if (launch_rd || launch_wr) begin
        pend    <= 1'b1;
        pend_rd <= launch_rd;
      end else if (state == BUS_IDLE && pend) begin
        pend <= 1'b0;
      end

      case (state)
        BUS_IDLE: begin
          if (pend) begin
            state  <= BUS_REQ;
            reg_wr <= ~pend_rd;
            reg_rd <= pend_rd;
            cur_rd <= pend_rd;
          end
        end
        BUS_REQ: begin
          state <= BUS_WAIT;
          timer <= '0;
        end
        BUS_WAIT: begin
          if (reg_ack) begin
            if (cur_rd) rd_buf <= reg_rdat;
            state <= BUS_IDLE;
          end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
            rd_buf <= DATA_W'(TIMEOUT_FILL);
            err    <= 1'b1;
            state  <= BUS_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= BUS_IDLE;
      endcase
    end
  end

endmodule
